// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger event stamping logic: state codes,
// default timestamp width and detect_pls bit assignments.
package trigger_pkg;

  localparam logic [2:0] ST_IDLE_C  = 3'b000;
  localparam logic [2:0] ST_ARMED_C = 3'b001;
  localparam logic [2:0] ST_FIRE_C  = 3'b011;
  localparam logic [2:0] ST_DONE_C  = 3'b010;
  localparam logic [2:0] ST_REARM_C = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_C,
    ST_ARMED = ST_ARMED_C,
    ST_FIRE  = ST_FIRE_C,
    ST_DONE  = ST_DONE_C,
    ST_REARM = ST_REARM_C
  } state_t;

  localparam int TS_WIDTH_DEF = 32;

  localparam int DET_ARMED = 0;
  localparam int DET_A     = 1;
  localparam int DET_B     = 2;
  localparam int DET_C     = 3;
  localparam int DET_FIRE  = 4;

endpackage

// File: rtl/trigger_event_stamp_if.sv
// Link between the trigger state machine (master) and the event stamp unit (slave).
// The link is level based: no valid/ready; detect_pls flags are sampled every rxclk edge.
interface trigger_event_stamp_if;
  logic        trig_enable;
  logic [7:0]  detect_pls;
  logic [31:0] pulse_tof;

  modport master (output detect_pls, output pulse_tof, input trig_enable);
  modport slave  (input detect_pls, input pulse_tof, output trig_enable);
endinterface

// File: rtl/pulse_stretch.sv
// Drives level high for max(width,1) cycles after start; abort drops it on the next edge.
// last is high during the final cycle of an unaborted pulse.
module pulse_stretch #(
  parameter int WIDTH_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WIDTH_BITS-1:0] width,
  output logic                  level,
  output logic                  last
);

  logic [WIDTH_BITS-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (abort) begin
      level <= 1'b0;
    end else if (start) begin
      level <= 1'b1;
      cnt   <= (width == '0) ? WIDTH_BITS'(1) : width;
    end else if (level) begin
      if (cnt == WIDTH_BITS'(1)) level <= 1'b0;
      else                       cnt   <= cnt - 1'b1;
    end
  end

  assign last = level && (cnt == WIDTH_BITS'(1));

endmodule

// File: rtl/trigger_event_stamp.sv
// Stamps trigger stages against a free-running counter and fires trig_out.
// Define TRIG_STAMP_REARM_EN to re-arm automatically after each shot.
import trigger_pkg::*;

module trigger_event_stamp #(
  parameter int TS_WIDTH     = TS_WIDTH_DEF,
  parameter int WIDTH_BITS   = 16,
  parameter int REARM_CYCLES = 16
) (
  input  logic                  rxclk,
  input  logic                  resetn,
  input  logic                  sw_enable,
  input  logic [WIDTH_BITS-1:0] out_width,
  trigger_event_stamp_if.slave  trig,
  output logic                  trig_out,
  output logic [TS_WIDTH-1:0]   event_ts_1,
  output logic [TS_WIDTH-1:0]   event_ts_2,
  output logic [TS_WIDTH-1:0]   event_ts_3,
  output logic [TS_WIDTH-1:0]   event_ts_4,
  output logic [31:0]           tof_latched,
  output logic [3:0]            stamp_valid,
  output logic [15:0]           shot_count,
  output logic [2:0]            state_o,
  output logic                  done
);

  localparam int RC_W = (REARM_CYCLES > 2) ? $clog2(REARM_CYCLES) : 1;

  state_t                state, state_nxt;
  logic [TS_WIDTH-1:0]   ts_cnt;
  logic [TS_WIDTH-1:0]   stamp_q [DET_A:DET_FIRE];
  logic [DET_FIRE:DET_A] det_prev, rise;
  logic [RC_W-1:0]       rearm_cnt;
  logic                  arm, fire, fire_done, stamp_en, ps_last;

  wire unused_det = ^{trig.detect_pls[7:DET_FIRE+1], trig.detect_pls[DET_ARMED]};

  assign rise     = trig.detect_pls[DET_FIRE:DET_A] & ~det_prev;
  assign stamp_en = (state == ST_ARMED) && sw_enable;

  always_ff @(posedge rxclk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Dropping sw_enable wins over every other transition, including mid-pulse.
  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    fire      = 1'b0;
    fire_done = 1'b0;
    if (!sw_enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_ARMED;
          arm       = 1'b1;
        end
        ST_ARMED: if (rise[DET_FIRE]) begin
          state_nxt = ST_FIRE;
          fire      = 1'b1;
        end
        ST_FIRE: if (ps_last) begin
          state_nxt = ST_DONE;
          fire_done = 1'b1;
        end
`ifdef TRIG_STAMP_REARM_EN
        ST_DONE: state_nxt = ST_REARM;
`else
        ST_DONE: state_nxt = ST_DONE;
`endif
        ST_REARM: if (rearm_cnt == '0) begin
          state_nxt = ST_ARMED;
          arm       = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // DONE plus REARM together hold trig_enable low for REARM_CYCLES cycles.
  always_ff @(posedge rxclk or negedge resetn) begin
    if (!resetn)                rearm_cnt <= '0;
    else if (state != ST_REARM) rearm_cnt <= RC_W'(REARM_CYCLES - 2);
    else if (rearm_cnt != '0)   rearm_cnt <= rearm_cnt - 1'b1;
  end

  // ts_cnt reads 0 on the first ARMED cycle, so an edge first sampled on the
  // Nth rxclk edge after the arm edge is stamped N-1.
  always_ff @(posedge rxclk or negedge resetn) begin
    if (!resetn) begin
      ts_cnt   <= '0;
      det_prev <= '0;
    end else if (arm) begin
      ts_cnt   <= '0;
      det_prev <= '0;
    end else begin
      det_prev <= trig.detect_pls[DET_FIRE:DET_A];
      if (state == ST_ARMED && ts_cnt != '1) ts_cnt <= ts_cnt + 1'b1;
    end
  end

  always_ff @(posedge rxclk or negedge resetn) begin
    if (!resetn) begin
      stamp_valid <= '0;
      for (int k = DET_A; k <= DET_FIRE; k++) stamp_q[k] <= '0;
    end else if (arm) begin
      stamp_valid <= '0;
    end else if (stamp_en) begin
      for (int k = DET_A; k <= DET_FIRE; k++) begin
        if (rise[k] && !stamp_valid[k-1]) begin
          stamp_q[k]       <= ts_cnt;
          stamp_valid[k-1] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge rxclk or negedge resetn) begin
    if (!resetn) begin
      tof_latched <= '0;
      shot_count  <= '0;
    end else begin
      if (fire)      tof_latched <= trig.pulse_tof;
      if (fire_done) shot_count  <= shot_count + 1'b1;
    end
  end

  pulse_stretch #(.WIDTH_BITS(WIDTH_BITS)) u_pulse (
    .clk   (rxclk),
    .rst_n (resetn),
    .start (fire),
    .abort (!sw_enable),
    .width (out_width),
    .level (trig_out),
    .last  (ps_last)
  );

  assign trig.trig_enable = (state == ST_ARMED) || (state == ST_FIRE);
  assign event_ts_1       = stamp_q[DET_A];
  assign event_ts_2       = stamp_q[DET_B];
  assign event_ts_3       = stamp_q[DET_C];
  assign event_ts_4       = stamp_q[DET_FIRE];
  assign state_o          = state;
  assign done             = (state == ST_DONE);

endmodule

// File: tb/tb_trigger_event_stamp.sv
// Bench for trigger_event_stamp: directed shots, one expected record per shot
// checked when done rises, plus abort and mid-operation reset checks.
module tb_trigger_event_stamp;

  localparam int EXP_W = 4*32 + 4 + 32 + 16 + 16;

  logic        rxclk;
  logic        resetn;
  logic        sw_enable;
  logic [15:0] out_width;
  logic        trig_out;
  logic [31:0] event_ts_1, event_ts_2, event_ts_3, event_ts_4;
  logic [31:0] tof_latched;
  logic [3:0]  stamp_valid;
  logic [15:0] shot_count;
  logic [2:0]  state_o;
  logic        done;

  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  trigger_event_stamp_if tif();

  trigger_event_stamp #(.TS_WIDTH(32), .WIDTH_BITS(16), .REARM_CYCLES(16)) dut (
    .rxclk       (rxclk),
    .resetn      (resetn),
    .sw_enable   (sw_enable),
    .out_width   (out_width),
    .trig        (tif),
    .trig_out    (trig_out),
    .event_ts_1  (event_ts_1),
    .event_ts_2  (event_ts_2),
    .event_ts_3  (event_ts_3),
    .event_ts_4  (event_ts_4),
    .tof_latched (tof_latched),
    .stamp_valid (stamp_valid),
    .shot_count  (shot_count),
    .state_o     (state_o),
    .done        (done)
  );

  // clock / reset
  initial begin
    rxclk = 1'b0;
    forever #4 rxclk = ~rxclk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge rxclk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_trig_enable"}, tif.trig_enable, 0);
    check({tag, "_trig_out"},    trig_out, 0);
    check({tag, "_done"},        done, 0);
    check({tag, "_state"},       state_o, 0);
    check({tag, "_stamp_valid"}, stamp_valid, 0);
    check({tag, "_shot_count"},  shot_count, 0);
    check({tag, "_tof"},         tof_latched, 0);
    check({tag, "_ts1"},         event_ts_1, 0);
    check({tag, "_ts2"},         event_ts_2, 0);
    check({tag, "_ts3"},         event_ts_3, 0);
    check({tag, "_ts4"},         event_ts_4, 0);
  endtask

  // driver: arm, raise bits k at off_k edges after the arm edge, fire, wait for DONE, disarm
  task automatic run_shot(input int off1, input int off2, input int off3, input int off4,
                          input logic [15:0] w, input logic [31:0] tof,
                          input bit glitch2, input logic [15:0] shot);
    logic [15:0] wexp;
    int          waited;
    wexp = (w == 16'd0) ? 16'd1 : w;
    exp_q.push_back({32'(off1 - 1), 32'(off2 - 1), 32'(off3 - 1), 32'(off4 - 1),
                     4'hF, tof, shot, wexp});
    check("idle_before_arm", state_o, 3'b000);
    out_width      = w;
    tif.detect_pls = 8'h00;
    tif.pulse_tof  = tof;
    sw_enable      = 1'b1;
    tick(1);
    check("armed_state", state_o, 3'b001);
    check("armed_trig_enable", tif.trig_enable, 1);
    for (int c = 1; c <= off4; c++) begin
      if (c == off1) tif.detect_pls[1] = 1'b1;
      if (c == off2) tif.detect_pls[2] = 1'b1;
      if (c == off3) tif.detect_pls[3] = 1'b1;
      if (c == off4) begin
        tif.detect_pls[4] = 1'b1;
        check("pre_fire_low", trig_out, 0);
      end
      if (glitch2 && c == off2 + 3) tif.detect_pls[2] = 1'b0;
      if (glitch2 && c == off2 + 6) tif.detect_pls[2] = 1'b1;
      tick(1);
    end
    tif.pulse_tof = 32'hFFFF_FFFF;
    out_width     = w + 16'd7;
    check("fire_trig_out", trig_out, 1);
    check("fire_state", state_o, 3'b011);
    check("fire_trig_enable", tif.trig_enable, 1);
    waited = 0;
    while (!done && waited < 100) begin
      tick(1);
      waited++;
    end
    check("done_seen", done, 1);
    check("done_trig_enable", tif.trig_enable, 0);
    tick(3);
    check("done_holds", state_o, 3'b010);
    sw_enable = 1'b0;
    tick(1);
    check("disarm_idle", state_o, 3'b000);
    check("disarm_stamps_held", stamp_valid, 4'hF);
    tif.detect_pls = 8'h00;
    tick(1);
  endtask

  // scoreboard monitor: one expected record per DONE entry
  initial begin : monitor
    int               hi_cnt;
    logic             done_prev;
    logic [EXP_W-1:0] pkt;
    hi_cnt    = 0;
    done_prev = 1'b0;
    forever begin
      @(negedge rxclk);
      if (trig_out) hi_cnt++;
      else if (!done) hi_cnt = 0;
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done actual=done required=no_shot_pending");
        end else begin
          pkt = exp_q.pop_front();
          check("sb_ts1",        event_ts_1,  pkt[195:164]);
          check("sb_ts2",        event_ts_2,  pkt[163:132]);
          check("sb_ts3",        event_ts_3,  pkt[131:100]);
          check("sb_ts4",        event_ts_4,  pkt[99:68]);
          check("sb_valid",      stamp_valid, pkt[67:64]);
          check("sb_tof",        tof_latched, pkt[63:32]);
          check("sb_shot_count", shot_count,  pkt[31:16]);
          check("sb_width",      64'(hi_cnt), pkt[15:0]);
        end
        hi_cnt = 0;
      end
      done_prev = done;
    end
  end

  initial begin
    resetn         = 1'b0;
    sw_enable      = 1'b0;
    out_width      = 16'd5;
    tif.detect_pls = 8'h00;
    tif.pulse_tof  = 32'h0;
    #5;
    check_zero("reset");
    tick(2);
    resetn = 1'b1;
    tick(2);
    check_zero("idle");

    run_shot(10, 2510, 5020, 6000, 16'd5,  32'h0000_1234, 1'b0, 16'd1);
    run_shot(3,  5,    7,    9,    16'd0,  32'hCAFE_F00D, 1'b0, 16'd2);
    run_shot(4,  6,    20,   30,   16'd2,  32'h0000_0042, 1'b1, 16'd3);
    run_shot(8,  8,    12,   15,   16'd3,  32'h8000_0001, 1'b0, 16'd4);

    // abort on FIRE cycle 2 of a 10-cycle pulse
    out_width = 16'd10;
    sw_enable = 1'b1;
    tick(1);
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) tif.detect_pls[4] = 1'b1;
      tick(1);
    end
    check("abort_fire1", trig_out, 1);
    tick(1);
    sw_enable = 1'b0;
    tick(1);
    check("abort_trig_out", trig_out, 0);
    check("abort_state", state_o, 3'b000);
    check("abort_shot_count", shot_count, 16'd4);
    check("abort_done", done, 0);
    check("abort_valid", stamp_valid, 4'b1000);
    check("abort_ts4", event_ts_4, 32'd4);
    tif.detect_pls = 8'h00;
    tick(2);

    // asynchronous reset while ARMED with a stamp taken
    sw_enable = 1'b1;
    tick(4);
    tif.detect_pls[1] = 1'b1;
    tick(2);
    check("pre_reset_valid", stamp_valid, 4'b0001);
    #2;
    resetn = 1'b0;
    #1;
    check_zero("async_reset");
    sw_enable      = 1'b0;
    tif.detect_pls = 8'h00;
    tick(1);
    resetn = 1'b1;
    tick(2);
    check("post_reset_state", state_o, 3'b000);

    tick(2);
    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
